// File: rtl/memory_pkg.sv
// ----------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the instruction memory path: field widths of the
// 8-bit instruction word, the loader's counter width and saturation limit,
// the loader FSM state encoding and the field packing helper.
// ----------------------------------------------------------------------------
package memory_pkg;

   localparam int OPCODE_W = 3;
   localparam int OPER_W   = 5;
   localparam int INSTR_W  = 8;
   localparam int ADDR_W   = 8;

   // count has to represent a completely filled 256-entry memory.
   localparam int                COUNT_W   = ADDR_W + 1;
   localparam logic [COUNT_W-1:0] COUNT_MAX = 9'd256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

   // Opcode occupies [7:5], operand [4:0]; the fetch side splits the byte
   // back along exactly these boundaries.
   function automatic logic [INSTR_W-1:0] pack_instr(
      input logic [OPCODE_W-1:0] opcode,
      input logic [OPER_W-1:0]   operand
   );
      return {opcode, operand};
   endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// ----------------------------------------------------------------------------
// instruction_loader_if
// Handshake and memory-write bundle of the instruction loader.
//   master : drives start / load_valid / load_last / OPCode / Four_Zero_Bits,
//            observes the memory write port and status.
//   slave  : the loader itself.
// Signals: start, load_valid, load_last, OPCode[2:0], Four_Zero_Bits[4:0],
//          load_ready, mem_we, mem_addr[7:0], mem_wdata[7:0], count[8:0],
//          busy, done, overflow.
// ----------------------------------------------------------------------------
interface instruction_loader_if;

   logic                             start;
   logic                             load_valid;
   logic                             load_last;
   logic [memory_pkg::OPCODE_W-1:0]  OPCode;
   logic [memory_pkg::OPER_W-1:0]    Four_Zero_Bits;
   logic                             load_ready;
   logic                             mem_we;
   logic [memory_pkg::ADDR_W-1:0]    mem_addr;
   logic [memory_pkg::INSTR_W-1:0]   mem_wdata;
   logic [memory_pkg::COUNT_W-1:0]   count;
   logic                             busy;
   logic                             done;
   logic                             overflow;

   modport master (
      output start, load_valid, load_last, OPCode, Four_Zero_Bits,
      input  load_ready, mem_we, mem_addr, mem_wdata, count, busy, done, overflow
   );

   modport slave (
      input  start, load_valid, load_last, OPCode, Four_Zero_Bits,
      output load_ready, mem_we, mem_addr, mem_wdata, count, busy, done, overflow
   );

endinterface

// File: rtl/instruction_encoder_.sv
// ----------------------------------------------------------------------------
// instruction_encoder_
// Purely combinational packer of the instruction fields into one byte.
//   OPCode[2:0]         -> instruction[7:5]
//   Four_Zero_Bits[4:0] -> instruction[4:0]  (bits [4:3] are Rs)
// ----------------------------------------------------------------------------
module instruction_encoder_
   import memory_pkg::*;
(
   input  logic [OPCODE_W-1:0] OPCode,
   input  logic [OPER_W-1:0]   Four_Zero_Bits,
   output logic [INSTR_W-1:0]  instruction
);

   assign instruction = pack_instr(OPCode, Four_Zero_Bits);

endmodule

// File: rtl/instruction_loader.sv
// ----------------------------------------------------------------------------
// instruction_loader
// Accepts instruction fields over a valid/ready handshake and writes the
// packed bytes into instruction memory at consecutive addresses starting at
// BASE_ADDR. One instruction every two cycles at most: LOAD accepts, WRITE
// strobes mem_we. The session ends on the instruction flagged load_last, or
// with a sticky overflow when LAST_ADDR is written without the last flag.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : handshake inputs, memory write port, count/busy/done/
//                  overflow status
// ----------------------------------------------------------------------------
module instruction_loader
   import memory_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF
)
(
   input  logic               clock,
   input  logic               reset,
   instruction_loader_if.slave bus
);

   loader_state_t          state;
   loader_state_t          state_nxt;

   logic [INSTR_W-1:0]     instr_enc;
   logic [ADDR_W-1:0]      mem_addr_q;
   logic [INSTR_W-1:0]     mem_wdata_q;
   logic [COUNT_W-1:0]     count_q;
   logic                   overflow_q;
   logic                   last_q;

   logic                   load_ready_c;
   logic                   mem_we_c;
   logic                   busy_c;
   logic                   done_c;

   function automatic logic [COUNT_W-1:0] count_sat_inc(input logic [COUNT_W-1:0] c);
      return (c == COUNT_MAX) ? c : c + 9'd1;
   endfunction

   instruction_encoder_ u_encoder (
      .OPCode         (bus.OPCode),
      .Four_Zero_Bits (bus.Four_Zero_Bits),
      .instruction    (instr_enc)
   );

   // ---- state register -----------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next state and state-decoded outputs -------------------------------
   always_comb begin
      state_nxt    = state;
      load_ready_c = 1'b0;
      mem_we_c     = 1'b0;
      busy_c       = 1'b0;
      done_c       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            load_ready_c = 1'b1;
            busy_c       = 1'b1;
            if (bus.load_valid) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we_c = 1'b1;
            busy_c   = 1'b1;
            // Either the session is complete or the memory is full.
            if (last_q || (mem_addr_q == LAST_ADDR)) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_LOAD;
            end
         end
         ST_DONE: begin
            done_c = 1'b1;
            if (bus.start) state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---- address, data, counter and error registers -------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  mem_addr_q <= BASE_ADDR;
                  count_q    <= '0;
                  overflow_q <= 1'b0;
                  last_q     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (bus.load_valid) begin
                  mem_wdata_q <= instr_enc;
                  last_q      <= bus.load_last;
               end
            end
            ST_WRITE: begin
               count_q <= count_sat_inc(count_q);
               // The address holds at LAST_ADDR rather than wrapping; a
               // further instruction is the overflow condition.
               if (!last_q) begin
                  if (mem_addr_q == LAST_ADDR) begin
                     overflow_q <= 1'b1;
                  end else begin
                     mem_addr_q <= mem_addr_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.load_ready = load_ready_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.count      = count_q;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.overflow   = overflow_q;

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: first instruction memory address written after each start.
REQ-002 Parameter LAST_ADDR, default 8'hFF: highest writable address; an overrun beyond it is an error.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begin a load session; sampled only in IDLE or DONE.
REQ-006 Port load_valid, input, 1: instruction fields present on OPCode/Four_Zero_Bits.
REQ-007 Port OPCode, input, 3: opcode field, packed into instruction bits [7:5].
REQ-008 Port Four_Zero_Bits, input, 5: operand field, packed into instruction bits [4:0]; bits [4:3] form Rs.
REQ-009 Port load_last, input, 1: qualifies the final instruction of the session; valid with load_valid.
REQ-010 Port load_ready, output, 1: loader accepts fields this cycle.
REQ-011 Port mem_we, output, 1: instruction memory write strobe, one cycle per instruction.
REQ-012 Port mem_addr, output, 8: write address, the PCinst value the fetch side later presents.
REQ-013 Port mem_wdata, output, 8: packed instruction byte.
REQ-014 Port count, output, 9: number of instructions written this session (0..256).
REQ-015 Port busy, output, 1: high in LOAD and WRITE.
REQ-016 Port done, output, 1: high while in DONE.
REQ-017 Port overflow, output, 1: sticky error, write attempted past LAST_ADDR.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-019 IDLE: start=1 SHALL go to LOAD, with mem_addr<=BASE_ADDR, count<=0 and overflow<=0.
REQ-020 LOAD: load_ready SHALL be 1; a transfer occurs when load_valid && load_ready; on transfer, latch mem_wdata={OPCode,Four_Zero_Bits[4:0]} and the last flag, then go to WRITE.
REQ-021 WRITE: mem_we SHALL be 1 for exactly one cycle with stable mem_addr and mem_wdata; load_ready SHALL be 0; count SHALL increment at the end of that cycle.
REQ-022 After WRITE: a latched last flag SHALL go to DONE; mem_addr==LAST_ADDR without the last flag SHALL set overflow and go to DONE; otherwise mem_addr SHALL increment by 1 and the FSM SHALL return to LOAD.
REQ-023 Throughput SHALL be one instruction per 2 cycles maximum; latency from the accepting edge to mem_we high SHALL be 1 cycle.
REQ-024 mem_addr SHALL never wrap past LAST_ADDR; count SHALL saturate at 256.
REQ-025 DONE: done SHALL be 1 and load_ready 0; start SHALL begin a new session as in IDLE; otherwise the FSM SHALL remain in DONE.
REQ-026 start asserted in LOAD or WRITE SHALL be ignored.
REQ-027 load_valid in IDLE, WRITE or DONE SHALL be ignored, with no write and no state change.
REQ-028 mem_we SHALL never be asserted outside WRITE.

Reset
REQ-029 reset SHALL asynchronously force the FSM to IDLE, regardless of state, including mid-WRITE.
REQ-030 reset SHALL force load_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, busy=0, done=0 and overflow=0.
REQ-031 The first active edge after reset release SHALL be a normal IDLE cycle.

Structure
REQ-032 Shared package memory_pkg SHALL hold the field widths (OPCODE_W=3, OPER_W=5, INSTR_W=8, ADDR_W=8) and the loader state encoding.
REQ-033 Field packing SHALL be a sub-module instruction_encoder_: OPCode and Four_Zero_Bits in, 8-bit instruction out, purely combinational, the exact inverse of the fetch-side field split.
REQ-034 All FSM, address and counter logic SHALL reside in instruction_loader.

Verification
REQ-035 Reset mid-session: a reset pulse during WRITE at address 8'h03 -> same cycle mem_we=0, mem_addr=8'h00, count=0, state IDLE.
REQ-036 Three-word load: start; fields (3'b000,5'b00000), (3'b100,5'b00001), (3'b000,5'b10010 with load_last) -> writes 8'h00@0, 8'h81@1, 8'h12@2; count=3; done=1.
REQ-037 Back-to-back: load_valid held high for 4 words -> mem_we pulses every 2nd cycle and the addresses are 0,1,2,3 with no skips.
REQ-038 Overflow: with LAST_ADDR=8'h03, 5 words without last -> 4 writes; overflow=1; done=1; no write to address 4.
REQ-039 Illegal stimulus: load_valid in IDLE and start during LOAD -> no mem_we and no address change.
REQ-040 Round trip: loaded image read back through the fetch memory at PCinst 0..2 -> OPCode/Rs/Four_Zero_Bits equal the encoder inputs.
